// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Registered single-issue ALU with valid/ready handshakes and a
//               bit-serial shifter (one bit per cycle) for sll/srl/sra.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            flush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [3:0]      aluControl,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            ltS,
    output logic            ltU
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_BRC = 4'b1001;
    localparam logic [3:0] OP_EQ  = 4'b1010;
    localparam logic [3:0] OP_LUI = 4'b1011;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            outValid_q, outValid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            ltS_q, ltS_d;
    logic            ltU_q, ltU_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [3:0]      shop_q, shop_d;

    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, is_shift, accept;
    logic [XLEN-1:0] alu_res, shift_next;

    assign shamt    = opB[SHW-1:0];
    assign lt_s     = $signed(opA) < $signed(opB);
    assign lt_u     = opA < opB;
    assign is_shift = (aluControl == OP_SLL) || (aluControl == OP_SRL) ||
                      (aluControl == OP_SRA);
    assign inReady  = (state_q == IDLE) && (!outValid_q || outReady) && !flush;
    assign accept   = inValid && inReady;

    // Shift codes reach this path only with a zero shift amount, so opA is exact.
    always_comb begin
        alu_res = '0;
        case (aluControl)
            OP_ADD:                 alu_res = opA + opB;
            OP_SUB, OP_BRC:         alu_res = opA - opB;
            OP_SLL, OP_SRL, OP_SRA: alu_res = opA;
            OP_XOR:                 alu_res = opA ^ opB;
            OP_OR:                  alu_res = opA | opB;
            OP_AND:                 alu_res = opA & opB;
            OP_SLT:                 alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_EQ:                  alu_res = {{(XLEN-1){1'b0}}, (opA == opB)};
            OP_LUI:                 alu_res = opB;
            default:                alu_res = '0;
        endcase
    end

    always_comb begin
        shift_next = shreg_q;
        case (shop_q)
            OP_SLL:  shift_next = {shreg_q[XLEN-2:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, shreg_q[XLEN-1:1]};
            OP_SRA:  shift_next = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
            default: shift_next = shreg_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        outValid_d = outValid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        ltS_d      = ltS_q;
        ltU_d      = ltU_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        shop_d     = shop_q;

        if (outValid_q && outReady) begin
            outValid_d = 1'b0;
        end

        if (flush) begin
            outValid_d = 1'b0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ltS_d = lt_s;
                        ltU_d = lt_u;
                        if (is_shift && (shamt != '0)) begin
                            shreg_d = opA;
                            cnt_d   = shamt;
                            shop_d  = aluControl;
                            state_d = SHIFT;
                        end else begin
                            result_d   = alu_res;
                            zero_d     = (alu_res == '0);
                            outValid_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shreg_d = shift_next;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        result_d   = shift_next;
                        zero_d     = (shift_next == '0);
                        outValid_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            ltS_q      <= 1'b0;
            ltU_q      <= 1'b0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            shop_q     <= '0;
        end else begin
            state_q    <= state_d;
            outValid_q <= outValid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            ltS_q      <= ltS_d;
            ltU_q      <= ltU_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            shop_q     <= shop_d;
        end
    end

    assign outValid = outValid_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign ltS      = ltS_q;
    assign ltU      = ltU_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed and randomized bench for alu_exec_unit with a
//               cycle-count transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstN;
    logic            flush;
    logic            inValid;
    logic            inReady;
    logic [3:0]      aluControl;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            ltS;
    logic            ltU;

    int n_checks = 0;
    int n_errors = 0;

    // Model: registered outputs plus remaining serial-shift cycles.
    logic            m_ov;
    logic [XLEN-1:0] m_res;
    logic [XLEN-1:0] m_pend;
    logic            m_zero, m_lts, m_ltu;
    int              m_busy;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .aluControl (aluControl),
        .opA        (opA),
        .opB        (opB),
        .outValid   (outValid),
        .outReady   (outReady),
        .result     (result),
        .zero       (zero),
        .ltS        (ltS),
        .ltU        (ltU)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] c, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        int unsigned s;
        s = b % XLEN;
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << s;
            4'd3:    return a ^ b;
            4'd4:    return a >> s;
            4'd5:    return a[XLEN-1] ? ~((~a) >> s) : (a >> s);
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9:    return a - b;
            4'd10:   return (a == b) ? 1 : 0;
            4'd11:   return b;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ov = 1'b0; m_res = '0; m_pend = '0; m_zero = 1'b1;
        m_lts = 1'b0; m_ltu = 1'b0; m_busy = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".outValid"}, {31'b0, outValid}, {31'b0, m_ov});
        chk({tag, ".result"},   result, m_res);
        chk({tag, ".zero"},     {31'b0, zero}, {31'b0, m_zero});
        chk({tag, ".ltS"},      {31'b0, ltS},  {31'b0, m_lts});
        chk({tag, ".ltU"},      {31'b0, ltU},  {31'b0, m_ltu});
    endtask

    // Entered and left at posedge+1: drives inputs, checks inReady, takes one edge.
    task automatic step(input logic v, input logic [3:0] c, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic ordy, input logic fl);
        logic exp_rdy, acc, is_sh;
        logic [XLEN-1:0] r;
        inValid = v; aluControl = c; opA = a; opB = b; outReady = ordy; flush = fl;
        #1;
        exp_rdy = (m_busy == 0) && (!m_ov || ordy) && !fl;
        chk("inReady", {31'b0, inReady}, {31'b0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        if (fl) begin
            m_ov = 1'b0;
            m_busy = 0;
        end else begin
            if (m_ov && ordy) m_ov = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_ov = 1'b1; m_res = m_pend; m_zero = (m_pend == 0);
                end
            end else if (acc) begin
                r = ref_alu(c, a, b);
                m_lts = ($signed(a) < $signed(b));
                m_ltu = (a < b);
                is_sh = (c == 4'd2) || (c == 4'd4) || (c == 4'd5);
                if (is_sh && (b % XLEN) != 0) begin
                    m_busy = b % XLEN;
                    m_pend = r;
                end else begin
                    m_ov = 1'b1; m_res = r; m_zero = (r == 0);
                end
            end
        end
        #1;
        check_outputs("step");
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; aluControl = '0;
        opA = '0; opB = '0; outReady = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // add wrap: 0xFFFFFFFF + 1
        step(1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        chk("add.result", result, 32'd0);
        chk("add.zero", {31'b0, zero}, 32'd1);
        chk("add.ltS", {31'b0, ltS}, 32'd1);
        chk("add.ltU", {31'b0, ltU}, 32'd0);

        // sra by 4 with upstream holding another op during SHIFT
        step(1'b1, 4'b0101, 32'h8000_0000, 32'd4, 1'b1, 1'b0);
        chk("sra.ov0", {31'b0, outValid}, 32'd0);
        repeat (4) step(1'b1, 4'b0000, 32'd9, 32'd9, 1'b1, 1'b0);
        chk("sra.result", result, 32'hF800_0000);
        chk("sra.ov", {31'b0, outValid}, 32'd1);
        step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);

        // backpressure: sub 5-3 held for three cycles
        step(1'b1, 4'b0001, 32'd5, 32'd3, 1'b0, 1'b0);
        repeat (3) step(1'b1, 4'b0011, 32'hA5, 32'h5A, 1'b0, 1'b0);
        chk("bp.result", result, 32'd2);
        step(1'b1, 4'b0011, 32'hA5, 32'h5A, 1'b1, 1'b0);
        chk("bp.next", result, 32'hFF);

        // back-to-back xor/or/and/slt
        step(1'b1, 4'b0011, 32'hF0F0, 32'h0FF0, 1'b1, 1'b0);
        chk("b2b.xor", result, 32'hFF00);
        step(1'b1, 4'b0110, 32'hF000, 32'h000F, 1'b1, 1'b0);
        chk("b2b.or", result, 32'hF00F);
        step(1'b1, 4'b0111, 32'hFF00, 32'h0FF0, 1'b1, 1'b0);
        chk("b2b.and", result, 32'h0F00);
        step(1'b1, 4'b1000, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0);
        chk("b2b.slt", result, 32'd1);
        step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);

        // flush during sll by 20
        step(1'b1, 4'b0010, 32'd1, 32'd20, 1'b1, 1'b0);
        repeat (4) step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 4'b0000, 32'd3, 32'd4, 1'b1, 1'b1);
        chk("flush.ov", {31'b0, outValid}, 32'd0);
        repeat (20) step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);

        // asynchronous reset between edges mid-SHIFT
        step(1'b1, 4'b0010, 32'd1, 32'd20, 1'b1, 1'b0);
        repeat (3) step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        model_reset();
        chk("arst.ov", {31'b0, outValid}, 32'd0);
        chk("arst.result", result, 32'd0);
        chk("arst.zero", {31'b0, zero}, 32'd1);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 4'b1010, 32'd7, 32'd7, 1'b1, 1'b0);
        chk("eq.result", result, 32'd1);
        chk("eq.zero", {31'b0, zero}, 32'd0);
        repeat (25) step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rstN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous kill of in-flight and presented op.
REQ-005 SHALL have port inValid  input  1  upstream op present.
REQ-006 SHALL have port inReady  output  1  unit accepts op this cycle.
REQ-007 SHALL have port aluControl  input  4  operation code from the ALU controller.
REQ-008 SHALL have ports opA and opB  input  XLEN  source operands.
REQ-009 SHALL have port outValid  output  1  result register holds a valid result.
REQ-010 SHALL have port outReady  input  1  downstream consumes result.
REQ-011 SHALL have port result  output  XLEN  registered result.
REQ-012 SHALL have ports zero, ltS, ltU  output  1 each  registered flags: result==0, signed opA<opB, unsigned opA<opB.

Function
REQ-013 SHALL transfer an op when inValid && inReady at a rising edge; SHALL transfer a result when outValid && outReady.
REQ-014 SHALL drive inReady = (state==IDLE) && (!outValid || outReady) && !flush.
REQ-015 SHALL decode aluControl: 0000 add, 0001 sub, 0010 sll, 0011 xor, 0100 srl, 0101 sra, 0110 or, 0111 and, 1000 slt (result 1/0, signed), 1001 branch compare (opA-opB), 1010 equality (result 1 if opA==opB else 0), 1011 upper-immediate (result=opB).
REQ-016 SHALL produce result 0 for codes 1100-1111, flags computed normally (zero=1).
REQ-017 SHALL perform add/sub modulo 2^XLEN, carry discarded.
REQ-018 SHALL use shift amount s = opB[log2(XLEN)-1:0]; upper opB bits ignored.
REQ-019 SHALL implement FSM states IDLE, SHIFT; outValid is a separate flag.
REQ-020 Non-shift op or shift with s==0: result and flags SHALL be registered at the accepting edge; outValid high the following cycle (latency 1); state stays IDLE.
REQ-021 Shift with s>0: accepting edge SHALL load opA into shift register, counter=s, state->SHIFT; each SHIFT edge shifts one bit (sll: zero fill left; srl: zero fill right; sra: sign fill) and decrements; on the edge counter goes 1->0, result loads, outValid sets, state->IDLE (latency s+1 cycles after accept edge inclusive, i.e. outValid visible s cycles after the non-shift case).
REQ-022 ltS/ltU SHALL be captured from the accepted operands at the accept edge, for every op.
REQ-023 result/flags SHALL hold stable while outValid && !outReady.
REQ-024 Simultaneous result drain and new accept SHALL be legal: outValid stays 1 with new result (back-to-back throughput 1/cycle for non-shift ops).
REQ-025 Drain without new completion SHALL clear outValid.
REQ-026 flush SHALL take priority: clears outValid, forces state IDLE, drops presented op; result/flag registers need not change.
REQ-027 inValid during SHIFT SHALL be ignored (inReady=0) and held upstream.

Reset
REQ-028 rstN low SHALL immediately set state=IDLE, outValid=0, result=0, zero=1, ltS=0, ltU=0, counter=0, regardless of clock.
REQ-029 Reset asserted mid-SHIFT SHALL abandon the op; no result emitted after release.
REQ-030 First accept SHALL be possible on the first rising edge after rstN deasserts.

Verification
REQ-031 add: opA=0xFFFFFFFF, opB=1, code 0000, outReady=1 -> next cycle result=0, zero=1, outValid=1, ltS=1, ltU=0.
REQ-032 sra: opA=0x80000000, opB=4, code 0101 -> outValid 4 cycles after non-shift timing, result=0xF8000000; inReady=0 throughout SHIFT.
REQ-033 Backpressure: sub 5-3 with outReady=0 for 3 cycles -> result=2 held, inReady=0, new inValid not accepted; outReady=1 -> next op accepted same edge.
REQ-034 Back-to-back: 4 ops xor/or/and/slt every cycle, outReady=1 -> 4 results on 4 consecutive cycles, correct order, no bubbles.
REQ-035 flush during SHIFT (sll opA=1, opB=20, flush at cycle 5) -> outValid never rises for that op, state IDLE, inReady=1 next cycle.
REQ-036 rstN pulsed low mid-SHIFT between clock edges -> outValid=0, result=0 immediately; beq-equality (code 1010, opA=opB=7) after release -> result=1, zero=0.
